lz64_seq: RTL and testbench

- Multi-cycle 64-bit leading-zero count sequencer for the scalar population/leading-zero functional unit.
- Time-shares one external 8-bit leading-zero sub-block across the operand bytes, scanning MSB byte first.
- Drives that sub-block's byte input, consumes its zero flag and zero count, and returns the full-width count through a start/done handshake.
- Sits between scalar operand issue and the result bus.

---
 rtl/lz64_seq.sv | 115 +++++++++++
 tb/tb_lz64_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz64_seq.sv
// lz64_seq: multi-cycle leading-zero count sequencer.
// Scans the operand MSB byte first through a shared external 8-bit
// leading-zero sub-block and returns the full-width count via start/done.
// Optional feature macro: LZ64_SEQ_ABORT_EN adds i_abort to cancel a scan.
module lz64_seq #(
    parameter int unsigned  WIDTH = 64,
    localparam int unsigned RW    = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
`ifdef LZ64_SEQ_ABORT_EN
    input  logic             i_abort,
`endif
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [RW-1:0]    o_result,
    output logic             o_zero,
    output logic [7:0]       o_lz_data,
    input  logic             i_lz_zbar,
    input  logic [2:0]       i_lz_zeros
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned IW     = $clog2(NBYTES);
    localparam logic [IW-1:0] LastIdx = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [RW-1:0]    result_q, result_d;
    logic             zero_q, zero_d;
    logic             abort;

`ifdef LZ64_SEQ_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    // Next-state and datapath updates; everything holds by default.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        result_d = result_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    shreg_d = i_data;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                // Abort wins over a same-cycle nonzero detection.
                if (abort) begin
                    state_d = StIdle;
                end else if (i_lz_zbar) begin
                    result_d = (RW'(idx_q) << 3) + RW'(i_lz_zeros);
                    zero_d   = 1'b0;
                    state_d  = StDone;
                end else if (idx_q == LastIdx) begin
                    result_d = RW'(WIDTH);
                    zero_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    shreg_d = {shreg_q[WIDTH-9:0], 8'h00};
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            idx_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Outputs decoded from state and registers; the sub-block sees the top byte.
    always_comb begin
        o_busy    = (state_q != StIdle);
        o_done    = (state_q == StDone);
        o_result  = result_q;
        o_zero    = zero_q;
        o_lz_data = shreg_q[WIDTH-1:WIDTH-8];
    end

endmodule

// File: tb/tb_lz64_seq.sv
// tb_lz64_seq: directed self-checking bench for lz64_seq with a result scoreboard.
module tb_lz64_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] data;
    logic        busy;
    logic        done;
    logic [6:0]  result;
    logic        zero;
    logic [7:0]  lz_data;
    logic        lz_zbar;
    logic [2:0]  lz_zeros;
`ifdef LZ64_SEQ_ABORT_EN
    logic        abort;
`endif

    typedef struct {
        logic [6:0] res;
        logic       zero;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic [6:0] last_res  = '0;
    logic       last_zero = 1'b0;

    lz64_seq #(.WIDTH(64)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
`ifdef LZ64_SEQ_ABORT_EN
        .i_abort    (abort),
`endif
        .i_start    (start),
        .i_data     (data),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result),
        .o_zero     (zero),
        .o_lz_data  (lz_data),
        .i_lz_zbar  (lz_zbar),
        .i_lz_zeros (lz_zeros)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit leading-zero sub-block, combinational from lz_data.
    always_comb begin
        lz_zbar  = |lz_data;
        lz_zeros = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (lz_data[i]) lz_zeros = 3'(7 - i);
        end
    end

    function automatic exp_t make_exp(input logic [63:0] d);
        exp_t e;
        bit   found;
        e.res  = 7'd64;
        e.zero = 1'b1;
        e.lat  = 9;
        found  = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!found && d[i]) begin
                found  = 1'b1;
                e.res  = 7'(63 - i);
                e.zero = 1'b0;
                e.lat  = (63 - i) / 8 + 2;
            end
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops the scoreboard and checks the completed result.
    task automatic retire(input int lat, input bit check_lat);
        exp_t e;
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("result", 64'(result), 64'(e.res));
            check("zero", 64'(zero), 64'(e.zero));
            if (check_lat) check("latency", 64'(lat), 64'(e.lat));
            last_res  = e.res;
            last_zero = e.zero;
        end
    endtask

    task automatic run_op(input logic [63:0] d);
        int          n;
        bit          got;
        logic [63:0] sh;
        logic [7:0]  eb;
        sb.push_back(make_exp(d));
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        data  = ~d;
        n     = 0;
        got   = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1'b1;
            end else begin
                sh = d << (8 * (n - 1));
                eb = sh[63:56];
                check("busy_scan", 64'(busy), 64'd1);
                check("lz_byte", 64'(lz_data), 64'(eb));
                if (n == 1) check("hold_result", 64'(result), 64'(last_res));
            end
        end
        check("done_seen", 64'(got), 64'd1);
        if (got) begin
            check("busy_done", 64'(busy), 64'd1);
            retire(n, 1'b1);
            @(negedge clk);
            check("done_single", 64'(done), 64'd0);
            check("idle_after", 64'(busy), 64'd0);
            check("hold_idle", 64'(result), 64'(last_res));
        end
    endtask

    initial begin
        int          idle_run;
        int          ops;
        int          ndone;
        bit          prev_done;
        logic [63:0] d;

        rst_n = 1'b0;
        start = 1'b0;
        data  = '0;
`ifdef LZ64_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_lz_data", 64'(lz_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(64'h8000_0000_0000_0000);
        run_op(64'h0000_1000_0000_0000);
        run_op(64'h0000_0000_0000_0001);
        run_op(64'h0000_0000_0000_0000);
        run_op(64'h0F00_0000_0000_0000);
        run_op(64'h0000_0000_0000_00FF);
        run_op(64'h0000_0000_0000_0000);

        // Start held high: only operands sampled while idle are processed.
        @(negedge clk);
        check("b2b_idle", 64'(busy), 64'd0);
        d = ({$urandom, $urandom}) >> $urandom_range(0, 63);
        start = 1'b1;
        data  = d;
        sb.push_back(make_exp(d));
        idle_run  = 1;
        ops       = 0;
        prev_done = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                check("b2b_done_single", 64'(prev_done), 64'd0);
                retire(0, 1'b0);
            end
            if (!busy) begin
                idle_run++;
            end else begin
                if (idle_run > 0) begin
                    if (ops > 0) check("b2b_idle_gap", 64'(idle_run), 64'd1);
                    ops++;
                end
                idle_run = 0;
            end
            prev_done = done;
            if (cyc == 59) begin
                start = 1'b0;
            end else begin
                d    = ({$urandom, $urandom}) >> $urandom_range(0, 63);
                data = d;
                if (!busy) sb.push_back(make_exp(d));
            end
        end
        for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (done) retire(0, 1'b0);
        end
        check("b2b_drained", 64'(sb.size()), 64'd0);
        check("b2b_ops", 64'(ops > 3), 64'd1);
        repeat (2) @(negedge clk);

        // Reset mid-scan after an all-zero result so reset values are visible.
        run_op(64'h0000_0000_0000_0000);
        @(negedge clk);
        start = 1'b1;
        data  = 64'h0000_0000_00FF_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_zero", 64'(zero), 64'd0);
        check("mid_rst_lz_data", 64'(lz_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_rst_no_done", 64'(ndone), 64'd0);
        last_res  = '0;
        last_zero = 1'b0;
        run_op(64'h0100_0000_0000_0000);

`ifdef LZ64_SEQ_ABORT_EN
        // Abort in the same cycle the first byte is found nonzero.
        run_op(64'h00FF_0000_0000_0000);
        @(negedge clk);
        start = 1'b1;
        data  = 64'h8000_0000_0000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_idle", 64'(busy), 64'd0);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_hold_result", 64'(result), 64'(last_res));
        check("abort_hold_zero", 64'(zero), 64'(last_zero));
        run_op(64'h0000_0000_0040_0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
